// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction fetch bus: imem request/response, redirect and instruction handshake
interface instr_fetch_if #(
  parameter int Width = 32
);
  logic             imem_req;
  logic [Width-1:0] imem_addr;
  logic             imem_rvalid;
  logic [Width-1:0] imem_rdata;
  logic             redirect;
  logic [Width-1:0] redirect_base;
  logic [Width-1:0] ImmOp;
  logic             instr_valid;
  logic [Width-1:0] instr;
  logic [Width-1:0] instr_pc;
  logic             instr_ready;
  logic             misaligned;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, misaligned,
    input  imem_rvalid, imem_rdata, redirect, redirect_base, ImmOp, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, misaligned,
    output imem_rvalid, imem_rdata, redirect, redirect_base, ImmOp, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit with epoch-tagged response buffer
// Optional misaligned-target halt enabled by defining IFETCH_MISALIGN_CHK_EN.
module instr_fetch #(
  parameter int               Width    = 32,
  parameter logic [Width-1:0] RESET_PC = '0,
  parameter int               DEPTH    = 2
) (
  input logic           clk,
  input logic           rst_n,
  instr_fetch_if.master bus
);
  localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OccW = PtrW + 2;

  typedef enum logic {RUN, HALT} state_t;

  state_t           state;
  logic [Width-1:0] fetch_pc;
  logic [Width-1:0] target;
  logic             target_bad;
  logic             epoch;
  logic             pend_valid;
  logic             pend_epoch;
  logic [Width-1:0] pend_addr;
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [PtrW:0]    count;
  logic [Width-1:0] buf_data [DEPTH];
  logic [Width-1:0] buf_pc   [DEPTH];
  logic             pop;
  logic             push;
  logic             pend_live;
  logic [OccW-1:0]  occupancy;

  assign target = bus.redirect_base + bus.ImmOp;

`ifdef IFETCH_MISALIGN_CHK_EN
  assign target_bad = |target[1:0];
`else
  assign target_bad = 1'b0;
`endif

  // Responses are only kept if issued in the current epoch and no flush is happening now.
  assign pend_live = pend_valid && (pend_epoch == epoch);
  assign push      = bus.imem_rvalid && pend_live && !bus.redirect;
  assign pop       = bus.instr_valid && bus.instr_ready;

  // Occupancy net of this cycle's dequeue keeps one request per cycle in steady state.
  assign occupancy = OccW'(count) - OccW'(pop) + OccW'(pend_live);

  assign bus.imem_req  = rst_n && (state == RUN) && !bus.redirect && (occupancy < OccW'(DEPTH));
  assign bus.imem_addr = fetch_pc;

  assign bus.instr_valid = (count != '0);
  assign bus.instr       = bus.instr_valid ? buf_data[rd_ptr] : '0;
  assign bus.instr_pc    = bus.instr_valid ? buf_pc[rd_ptr]   : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      fetch_pc       <= RESET_PC;
      epoch          <= 1'b0;
      pend_valid     <= 1'b0;
      pend_epoch     <= 1'b0;
      pend_addr      <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      bus.misaligned <= 1'b0;
    end else begin
      pend_valid <= bus.imem_req;
      pend_addr  <= fetch_pc;
      pend_epoch <= epoch;
      if (bus.redirect) begin
        epoch  <= ~epoch;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        if (target_bad) begin
          state          <= HALT;
          bus.misaligned <= 1'b1;
        end else begin
          state          <= RUN;
          bus.misaligned <= 1'b0;
          fetch_pc       <= target & ~Width'(3);
        end
      end else begin
        if (bus.imem_req) begin
          fetch_pc <= fetch_pc + Width'(4);
        end
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count <= count + (PtrW+1)'(push) - (PtrW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= bus.imem_rdata;
      buf_pc[wr_ptr]   <= pend_addr;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - table-driven bench for instr_fetch with addr-as-data memory
module tb_instr_fetch;
  typedef struct {
    logic        redirect;
    logic [31:0] base;
    logic [31:0] imm;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic        mis;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  instr_fetch_if #(.Width(32)) bif ();
  instr_fetch_if #(.Width(32)) bif2 ();

  instr_fetch #(.Width(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  instr_fetch #(.Width(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [31:0] b, input logic [31:0] im,
                              input logic rdy, input logic rq, input logic [31:0] a,
                              input logic v, input logic [31:0] p, input logic m);
    vec_t t;
    t.redirect = r; t.base = b; t.imm = im; t.ready = rdy;
    t.req = rq; t.addr = a; t.valid = v; t.pc = p; t.mis = m;
    return t;
  endfunction

  vec_t        tbl[$];
  logic        req_s, req_s2;
  logic [31:0] addr_s, addr_s2;
  logic [31:0] wrap_pc [3];

  initial begin
    wrap_pc[0] = 32'hFFFF_FFF8;
    wrap_pc[1] = 32'hFFFF_FFFC;
    wrap_pc[2] = 32'h0000_0000;

    // startup and streaming
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h04, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h08, 1, 32'h00, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h0C, 1, 32'h04, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h10, 1, 32'h08, 0));
    // ten-cycle stall: buffer fills to DEPTH, head held
    for (int k = 0; k < 10; k++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h0C, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h14, 1, 32'h0C, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h18, 1, 32'h10, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h1C, 1, 32'h14, 0));
    // redirect with handshake in the same cycle: 0x40 + (-8) = 0x38
    tbl.push_back(mk(1, 32'h40, 32'hFFFF_FFF8, 1, 0, 0, 1, 32'h18, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h38, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h3C, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h40, 1, 32'h38, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h44, 1, 32'h3C, 0));
    // back-to-back redirects, last wins
    tbl.push_back(mk(1, 32'h100, 32'h0, 1, 0, 0, 1, 32'h40, 0));
    tbl.push_back(mk(1, 32'h200, 32'h4, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h204, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h208, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h20C, 1, 32'h204, 0));
    // misaligned redirect target 0x102
    tbl.push_back(mk(1, 32'h100, 32'h2, 1, 0, 0, 1, 32'h208, 0));
`ifdef IFETCH_MISALIGN_CHK_EN
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 32'h200, 32'h0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h200, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h204, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h208, 1, 32'h200, 0));
`else
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h100, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h104, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h108, 1, 32'h100, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h10C, 1, 32'h104, 0));
`endif

    bif.imem_rvalid = 0; bif.imem_rdata = 0; bif.redirect = 0;
    bif.redirect_base = 0; bif.ImmOp = 0; bif.instr_ready = 0;
    bif2.imem_rvalid = 0; bif2.imem_rdata = 0; bif2.redirect = 0;
    bif2.redirect_base = 0; bif2.ImmOp = 0; bif2.instr_ready = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset imem_req", 32'(bif.imem_req), 0);
    check("reset instr_valid", 32'(bif.instr_valid), 0);
    check("reset instr", bif.instr, 0);
    check("reset instr_pc", bif.instr_pc, 0);
    check("reset misaligned", 32'(bif.misaligned), 0);
    @(posedge clk); #1;
    rst_n = 1;

    foreach (tbl[i]) begin
      bif.redirect      = tbl[i].redirect;
      bif.redirect_base = tbl[i].base;
      bif.ImmOp         = tbl[i].imm;
      bif.instr_ready   = tbl[i].ready;
      @(negedge clk);
      check($sformatf("row%0d imem_req", i), 32'(bif.imem_req), 32'(tbl[i].req));
      if (tbl[i].req) check($sformatf("row%0d imem_addr", i), bif.imem_addr, tbl[i].addr);
      check($sformatf("row%0d instr_valid", i), 32'(bif.instr_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) begin
        check($sformatf("row%0d instr_pc", i), bif.instr_pc, tbl[i].pc);
        check($sformatf("row%0d instr", i), bif.instr, tbl[i].pc);
      end
      check($sformatf("row%0d misaligned", i), 32'(bif.misaligned), 32'(tbl[i].mis));
      if (i == 0) check("wrap first imem_addr", bif2.imem_addr, 32'hFFFF_FFF8);
      if (i >= 2 && i <= 4) begin
        check($sformatf("wrap%0d instr_valid", i), 32'(bif2.instr_valid), 1);
        check($sformatf("wrap%0d instr_pc", i), bif2.instr_pc, wrap_pc[i-2]);
      end
      req_s = bif.imem_req;   addr_s = bif.imem_addr;
      req_s2 = bif2.imem_req; addr_s2 = bif2.imem_addr;
      @(posedge clk); #1;
      bif.imem_rvalid  = req_s;  bif.imem_rdata  = addr_s;
      bif2.imem_rvalid = req_s2; bif2.imem_rdata = addr_s2;
    end

    // reset mid-stream while a response is pending
    bif.redirect = 0;
    check("pending before reset", 32'(bif.imem_rvalid), 1);
    rst_n = 0;
    #1;
    check("midreset imem_req", 32'(bif.imem_req), 0);
    check("midreset instr_valid", 32'(bif.instr_valid), 0);
    check("midreset instr", bif.instr, 0);
    check("midreset instr_pc", bif.instr_pc, 0);
    check("midreset misaligned", 32'(bif.misaligned), 0);
    @(negedge clk);
    rst_n = 1;
    bif.imem_rvalid = 1;
    bif.imem_rdata  = 32'hDEAD_BEEF;
    #1;
    check("restart imem_req", 32'(bif.imem_req), 1);
    check("restart imem_addr", bif.imem_addr, 32'h0);
    @(posedge clk); #1;
    bif.imem_rvalid = 1; bif.imem_rdata = 32'h0;
    @(negedge clk);
    check("restart stale dropped", 32'(bif.instr_valid), 0);
    check("restart second addr", bif.imem_addr, 32'h4);
    @(posedge clk); #1;
    bif.imem_rvalid = 1; bif.imem_rdata = 32'h4;
    @(negedge clk);
    check("restart first valid", 32'(bif.instr_valid), 1);
    check("restart first pc", bif.instr_pc, 32'h0);
    check("restart first instr", bif.instr, 32'h0);
    @(posedge clk); #1;
    bif.imem_rvalid = 1; bif.imem_rdata = 32'h8;
    @(negedge clk);
    check("restart second pc", bif.instr_pc, 32'h4);
    check("restart second instr", bif.instr, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter Width, default 32, meaning datapath/instruction/address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-003 SHALL have parameter DEPTH, default 2, meaning instruction buffer entries (power of two, >=2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 imem_req  output  1  fetch request to instruction memory this cycle.
REQ-007 imem_addr  output  Width  word-aligned fetch address.
REQ-008 imem_rvalid  input  1  read data valid, exactly 1 cycle after an accepted imem_req.
REQ-009 imem_rdata  input  Width  fetched instruction word.
REQ-010 redirect  input  1  taken branch/jump; overrides sequential fetch.
REQ-011 redirect_base  input  Width  PC of the redirecting instruction.
REQ-012 ImmOp  input  Width  sign-extended offset from the immediate stage.
REQ-013 instr_valid  output  1  instr/instr_pc hold a valid instruction.
REQ-014 instr  output  Width  instruction word to decode and immediate stages.
REQ-015 instr_pc  output  Width  address of instr.
REQ-016 instr_ready  input  1  downstream accepts; transfer when instr_valid && instr_ready.
REQ-017 misaligned  output  1  redirect target not word-aligned (meaningful only with REQ-035).

Function
REQ-018 fetch_pc SHALL advance by 4 (modulo 2^Width, 32'hFFFF_FFFC wraps to 0) on each accepted imem_req.
REQ-019 imem_req SHALL assert only when buffer occupancy + in-flight requests < DEPTH and state is RUN.
REQ-020 imem_addr SHALL equal fetch_pc whenever imem_req is high.
REQ-021 Each imem_rvalid response SHALL be written to the FIFO tail with its request address; no response is dropped except per REQ-025.
REQ-022 instr/instr_pc SHALL present the FIFO head; instr_valid = FIFO non-empty.
REQ-023 instr SHALL remain stable while instr_valid && !instr_ready.
REQ-024 Simultaneous FIFO write and read SHALL keep occupancy unchanged; write to full FIFO SHALL be impossible by REQ-019.
REQ-025 On redirect: target = redirect_base + ImmOp (Width-bit, wrap); FIFO flushed that cycle; epoch bit toggled; responses tagged with old epoch discarded; fetch_pc = target next cycle.
REQ-026 imem_req SHALL be low in the redirect cycle; first target request issues the following cycle (redirect-to-request latency 1).
REQ-027 Redirect coinciding with a downstream handshake SHALL take priority; the handshaken word is consumed and all others flushed.
REQ-028 Back-to-back redirects SHALL each take effect; last one wins.
REQ-029 Steady-state throughput with instr_ready=1: one instruction per cycle after a 2-cycle startup (request, response).
REQ-030 States: RUN (normal) and HALT (entered per REQ-035; left only by reset or an aligned redirect).

Reset
REQ-031 On rst_n low, asynchronously: fetch_pc=RESET_PC, FIFO empty, in-flight count 0, epoch 0, state RUN, misaligned 0.
REQ-032 During reset: imem_req=0, instr_valid=0, instr=0, instr_pc=0.
REQ-033 Reset mid-operation SHALL discard in-flight responses; imem_rvalid in first cycle after deassertion is ignored.
REQ-034 First imem_req SHALL occur in the first rising edge cycle after rst_n deasserts.

Configuration
REQ-035 With IFETCH_MISALIGN_CHK_EN defined: redirect target with bits[1:0] != 0 sets misaligned=1 (held), flushes FIFO, enters HALT with imem_req=0.
REQ-036 Without IFETCH_MISALIGN_CHK_EN: target bits[1:0] forced to 0, misaligned tied 0, HALT unreachable.

Verification
REQ-037 Reset release, instr_ready=1, memory returns addr-as-data -> instr_pc 0,4,8,... one per cycle from cycle 2.
REQ-038 instr_ready=0 for 10 cycles -> exactly DEPTH entries buffered, imem_req low, instr stable; ready=1 -> no loss/duplication.
REQ-039 redirect_base=32'h40, ImmOp=32'hFFFF_FFF8 -> next instr_pc=32'h38; stale in-flight word not delivered.
REQ-040 RESET_PC=32'hFFFF_FFF8 -> instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-041 Macro defined, redirect_base=0x100, ImmOp=0x2 -> misaligned=1, imem_req=0 until redirect to 0x200; macro undefined -> fetch at 0x100.
REQ-042 rst_n pulsed low mid-stream with response pending -> outputs 0 immediately; restart at RESET_PC, pending word never appears.
